// File: rtl/lfsr_rng_pool_if.sv
// Stream, seed and status signals of lfsr_rng_pool.
// The master modport is the host/consumer side and the slave modport is the generator side.
interface lfsr_rng_pool_if #(
  parameter int unsigned SEED_WIDTH   = 32,
  parameter int unsigned OUTPUT_WIDTH = 16,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned LVL_W        = 3
);
  logic                    generate_enable;
  logic                    seed_load;
  logic [CH_W-1:0]         seed_ch;
  logic [SEED_WIDTH-1:0]   seed_data;
  logic                    rd_ready;
  logic [OUTPUT_WIDTH-1:0] random_out;
  logic [CH_W-1:0]         random_ch;
  logic                    random_valid;
  logic [LVL_W-1:0]        fifo_level;
  logic [63:0]             key_material;
  logic                    health_fail;

  modport master (
    output generate_enable, seed_load, seed_ch, seed_data, rd_ready,
    input  random_out, random_ch, random_valid, fifo_level, key_material, health_fail
  );

  modport slave (
    input  generate_enable, seed_load, seed_ch, seed_data, rd_ready,
    output random_out, random_ch, random_valid, fifo_level, key_material, health_fail
  );
endinterface

// File: rtl/lfsr_rng_pool.sv
// NUM_CH-lane LFSR random generator, round-robin into a first-word-fall-through FIFO.
// Define RNG_HEALTH_TEST_EN to build the repetition-count health test.
module lfsr_rng_pool #(
  parameter int unsigned SEED_WIDTH     = 32,
  parameter int unsigned OUTPUT_WIDTH   = 16,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [95:0] ENTROPY_SOURCE = 96'hDEADBEEFCAFEBABE12345678,
  parameter int unsigned REP_LIMIT      = 4
) (
  input logic            clk,
  input logic            rst,
  lfsr_rng_pool_if.slave bus_io
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned ENT_W = OUTPUT_WIDTH + CH_W;
  localparam logic [SEED_WIDTH-1:0] RESET_SEED = ENTROPY_SOURCE[SEED_WIDTH-1:0];
  localparam logic [SEED_WIDTH-1:0] TAP_MASK =
      (SEED_WIDTH == 32) ? SEED_WIDTH'(32'h8020_0003) :
      (SEED_WIDTH == 16) ? SEED_WIDTH'(16'hB400) :
      ((SEED_WIDTH'(1) << (SEED_WIDTH - 1)) | (SEED_WIDTH'(1) << (SEED_WIDTH / 2)));

  logic [SEED_WIDTH-1:0]   lfsr_q [NUM_CH];
  logic [SEED_WIDTH-1:0]   lfsr_d [NUM_CH];
  logic [SEED_WIDTH-1:0]   cur_state, adv_state, seed_val;
  logic [95:0]             pool_q, pool_d;
  logic [CH_W-1:0]         rr_q, rr_d;
  logic                    gen_q;
  logic [ENT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [63:0]             key_q;
  logic [OUTPUT_WIDTH-1:0] push_data;
  logic                    health_fail, push, pop, valid;

  always_comb begin
    cur_state = lfsr_q[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (rr_q == CH_W'(i)) cur_state = lfsr_q[i];
    end
    // Shift left, feedback into bit 0; an all-zero result would lock the lane up.
    adv_state = {cur_state[SEED_WIDTH-2:0], ^(cur_state & TAP_MASK)};
    if (adv_state == '0) adv_state = RESET_SEED;
    seed_val  = (bus_io.seed_data == '0) ? RESET_SEED : bus_io.seed_data;
    push_data = cur_state[OUTPUT_WIDTH-1:0];

    valid = (level_q != '0);
    push  = gen_q && (level_q < LVL_W'(FIFO_DEPTH)) && !health_fail && !bus_io.seed_load;
    pop   = valid && bus_io.rd_ready;

    for (int i = 0; i < NUM_CH; i++) begin
      lfsr_d[i] = lfsr_q[i];
      if (bus_io.seed_load && (int'(bus_io.seed_ch) == i)) lfsr_d[i] = seed_val;
      else if (push && (rr_q == CH_W'(i)))                lfsr_d[i] = adv_state;
    end

    rr_d = rr_q;
    if (push) rr_d = (rr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_q + CH_W'(1);

    pool_d = push ? {pool_q[94:0], pool_q[95] ^ pool_q[47] ^ pool_q[15]} : pool_q;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) lfsr_q[i] <= RESET_SEED;
      pool_q  <= ENTROPY_SOURCE;
      rr_q    <= '0;
      gen_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      key_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) lfsr_q[i] <= lfsr_d[i];
      pool_q  <= pool_d;
      rr_q    <= rr_d;
      gen_q   <= bus_io.generate_enable;
      level_q <= level_d;
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
        key_q  <= 64'(cur_state) ^ pool_q[63:0];
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= {push_data, rr_q};
  end

`ifdef RNG_HEALTH_TEST_EN
  localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

  logic [REP_W-1:0]        rep_q, rep_d;
  logic [OUTPUT_WIDTH-1:0] last_q;
  logic                    health_q;

  // rep_q == 0 means no word pushed since reset/reseed, so nothing to compare against.
  assign rep_d = ((rep_q != '0) && (push_data == last_q)) ? rep_q + REP_W'(1) : REP_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q    <= '0;
      last_q   <= '0;
      health_q <= 1'b0;
    end else if (bus_io.seed_load) begin
      rep_q    <= '0;
      health_q <= 1'b0;
    end else if (push) begin
      rep_q  <= rep_d;
      last_q <= push_data;
      if (rep_d >= REP_W'(REP_LIMIT)) health_q <= 1'b1;
    end
  end

  assign health_fail = health_q;
`else
  assign health_fail = 1'b0;
`endif

  assign bus_io.random_valid = valid;
  assign bus_io.fifo_level   = level_q;
  assign bus_io.random_out   = valid ? mem_q[rptr_q][ENT_W-1:CH_W] : '0;
  assign bus_io.random_ch    = valid ? mem_q[rptr_q][CH_W-1:0] : '0;
  assign bus_io.key_material = key_q;
  assign bus_io.health_fail  = health_fail;
endmodule

// File: tb/tb_lfsr_rng_pool.sv
// Directed bench for lfsr_rng_pool: a 1-lane instance driven from a vector table and a
// 4-lane instance driven through hand-written fill/reseed/reset/health sequences.
module tb_lfsr_rng_pool;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lfsr_rng_pool_if #(.SEED_WIDTH(32), .OUTPUT_WIDTH(16), .CH_W(2), .LVL_W(3)) b4 ();
  lfsr_rng_pool_if #(.SEED_WIDTH(32), .OUTPUT_WIDTH(16), .CH_W(1), .LVL_W(3)) b1 ();

  lfsr_rng_pool #(.NUM_CH(4)) u_dut4 (.clk(clk), .rst(rst), .bus_io(b4));
  lfsr_rng_pool #(.NUM_CH(1)) u_dut1 (.clk(clk), .rst(rst), .bus_io(b1));

  always #5 clk = ~clk;

  typedef struct {
    logic        gen;
    logic        sload;
    logic [31:0] sdata;
    logic        rdy;
    logic        exp_valid;
    logic [15:0] exp_out;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_heads [4];
  logic        exp_health;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
`ifdef RNG_HEALTH_TEST_EN
    exp_health = 1'b1;
`else
    exp_health = 1'b0;
`endif
    b4.generate_enable = 0; b4.seed_load = 0; b4.seed_ch = '0; b4.seed_data = '0; b4.rd_ready = 0;
    b1.generate_enable = 0; b1.seed_load = 0; b1.seed_ch = '0; b1.seed_data = '0; b1.rd_ready = 0;

    //              gen sld sdata  rdy  vld out       lvl
    vecs[0]  = '{1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 16'h0001, 3'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 16'h0003, 3'd1};
    vecs[3]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 16'h0006, 3'd1};
    vecs[4]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 16'h0006, 3'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 16'h0006, 3'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 16'h0006, 3'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 16'h000D, 3'd2};
    vecs[8]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 16'h001B, 3'd1};
    vecs[9]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[11] = '{1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[12] = '{1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[13] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 16'h5678, 3'd1};
    vecs[14] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 16'h5678, 3'd1};

    tick();
    tick();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 64'(b4.random_valid), 64'd0);
      chk("idle_level", 64'(b4.fifo_level), 64'd0);
      chk("idle_key", b4.key_material, 64'd0);
      chk("idle_health", 64'(b4.health_fail), 64'd0);
    end

    // Single-lane vectors: sequence 1,3,6,D,1B, latency, pops, zero-seed reload.
    for (int i = 0; i < 15; i++) begin
      b1.generate_enable = vecs[i].gen;
      b1.seed_load       = vecs[i].sload;
      b1.seed_data       = vecs[i].sdata;
      b1.rd_ready        = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(b1.random_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_out", i), 64'(b1.random_out), 64'(vecs[i].exp_out));
      chk($sformatf("vec%0d_ch", i), 64'(b1.random_ch), 64'd0);
      chk($sformatf("vec%0d_level", i), 64'(b1.fifo_level), 64'(vecs[i].exp_level));
    end
    b1.generate_enable = 0; b1.seed_load = 0; b1.rd_ready = 0;

    // Four lanes, consumer stalled: fill to full, then hold.
    b4.generate_enable = 1;
    b4.rd_ready = 0;
    tick();
    chk("fill_latency", 64'(b4.fifo_level), 64'd0);
    tick();
    chk("fill_lvl1", 64'(b4.fifo_level), 64'd1);
    chk("fill_head", 64'(b4.random_out), 64'h5678);
    chk("key_push1", b4.key_material, 64'hCAFEBABE00000000);
    tick();
    chk("fill_lvl2", 64'(b4.fifo_level), 64'd2);
    chk("key_push2", b4.key_material, 64'h95FD757C365CFA88);
    tick();
    tick();
    chk("fill_lvl4", 64'(b4.fifo_level), 64'd4);
    chk("fill_health", 64'(b4.health_fail), 64'(exp_health));
    tick();
    tick();
    chk("full_hold", 64'(b4.fifo_level), 64'd4);
    b4.generate_enable = 0;
    tick();
    tick();
    // Reseed ch3 with the state it already holds; clears any health trip.
    b4.seed_load = 1; b4.seed_ch = 2'd3; b4.seed_data = 32'h2468ACF1;
    tick();
    b4.seed_load = 0;
    chk("seed_keeps_level", 64'(b4.fifo_level), 64'd4);
    chk("seed_clears_health", 64'(b4.health_fail), 64'd0);
    b4.rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_ch", i), 64'(b4.random_ch), 64'(i));
      chk($sformatf("drain%0d_out", i), 64'(b4.random_out), 64'h5678);
      tick();
    end
    chk("drain_valid", 64'(b4.random_valid), 64'd0);

    // ch0 advanced exactly once while full, and rr_ptr wrapped to 0.
    b4.generate_enable = 1;
    tick();
    tick();
    chk("resume_ch", 64'(b4.random_ch), 64'd0);
    chk("resume_out", 64'(b4.random_out), 64'hACF1);

    // Zero seed on ch2 reloads ENTROPY_SOURCE[31:0]; push suppressed that cycle.
    b4.rd_ready = 0;
    b4.seed_load = 1; b4.seed_ch = 2'd2; b4.seed_data = 32'd0;
    tick();
    chk("seed_suppress", 64'(b4.fifo_level), 64'd1);
    b4.seed_load = 0;
    tick();
    chk("post_seed_lvl", 64'(b4.fifo_level), 64'd2);
    tick();
    b4.generate_enable = 0;
    tick();
    tick();
    chk("post_seed_full", 64'(b4.fifo_level), 64'd4);
    exp_heads[0] = 16'hACF1; exp_heads[1] = 16'hACF1;
    exp_heads[2] = 16'h5678; exp_heads[3] = 16'hACF1;
    b4.rd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reseed%0d_ch", i), 64'(b4.random_ch), 64'(i));
      chk($sformatf("reseed%0d_out", i), 64'(b4.random_out), 64'(exp_heads[i]));
      tick();
    end

    // Reset with three words queued.
    b4.rd_ready = 0;
    b4.generate_enable = 1;
    tick();
    tick();
    tick();
    b4.generate_enable = 0;
    tick();
    chk("pre_rst_level", 64'(b4.fifo_level), 64'd3);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_level", 64'(b4.fifo_level), 64'd0);
    chk("rst_valid", 64'(b4.random_valid), 64'd0);
    chk("rst_key", b4.key_material, 64'd0);
    b4.generate_enable = 1;
    tick();
    tick();
    chk("rst_rr_ch", 64'(b4.random_ch), 64'd0);
    chk("rst_rr_out", 64'(b4.random_out), 64'h5678);

    // Health: every lane seeded to 1 gives four identical words.
    b4.generate_enable = 0;
    b4.rd_ready = 1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      b4.seed_load = 1; b4.seed_ch = 2'(i); b4.seed_data = 32'd1;
      tick();
    end
    b4.seed_load = 0;
    chk("hl_empty", 64'(b4.fifo_level), 64'd0);
    b4.rd_ready = 0;
    b4.generate_enable = 1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("hl_level", 64'(b4.fifo_level), 64'd4);
    chk("hl_head", 64'(b4.random_out), 64'h0001);
    chk("hl_fail", 64'(b4.health_fail), 64'(exp_health));
    b4.rd_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("hl_stop", 64'(b4.fifo_level), exp_health ? 64'd0 : 64'd3);
    b4.seed_load = 1; b4.seed_ch = 2'd0; b4.seed_data = 32'd5;
    tick();
    b4.seed_load = 0;
    chk("hl_clear", 64'(b4.health_fail), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lfsr_rng_pool.md
# lfsr_rng_pool

Multi-channel LFSR random-number generator with a buffered valid/ready output stream. It generalises the single-channel RNG host to NUM_CH independent LFSR lanes with per-lane reseeding and a FIFO-backed output, plus an optional repetition-count health test. It sits between the platform entropy/seed interface and downstream consumers of random words and 64-bit key material.

## Interface
- SEED_WIDTH, 32: LFSR width per channel; taps 32:{31,21,1,0}, 16:{15,13,12,10}, other:{W-1,W/2}
- OUTPUT_WIDTH, 16: output word width; must be ≤ SEED_WIDTH
- NUM_CH, 4: channel count, 1..8; CH_W = max(1, clog2(NUM_CH))
- FIFO_DEPTH, 4: output FIFO depth, power of two, ≥2
- ENTROPY_SOURCE, 96'hDEADBEEFCAFEBABE12345678: reset seed/entropy-pool value
- REP_LIMIT, 4: identical consecutive pushes that trip the health test, ≥2
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- generate_enable  in  1  request generation; registered once internally (gen_sync)
- seed_load  in  1  load seed_data into channel seed_ch this cycle
- seed_ch  in  CH_W  target channel; values ≥ NUM_CH ignored
- seed_data  in  SEED_WIDTH  seed; zero means use ENTROPY_SOURCE[SEED_WIDTH-1:0]
- rd_ready  in  1  consumer accepts head word
- random_out  out  OUTPUT_WIDTH  FIFO head data
- random_ch  out  CH_W  channel that produced random_out
- random_valid  out  1  FIFO non-empty
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- key_material  out  64  last-pushed LFSR state (zero-extended/truncated to 64) XOR entropy_pool[63:0]
- health_fail  out  1  sticky health-test failure

## Operation
- Reset: every LFSR = ENTROPY_SOURCE[SEED_WIDTH-1:0]; entropy_pool = ENTROPY_SOURCE; rr_ptr = 0; FIFO empty; gen_sync = 0; key_material = 0; health_fail = 0; rep_cnt = 0. Outputs: random_out 0, random_ch 0, random_valid 0, fifo_level 0.
- Push condition: gen_sync && fifo_level < FIFO_DEPTH && !health_fail && !seed_load.
- On push: write {lfsr[rr_ptr][OUTPUT_WIDTH-1:0], rr_ptr} (pre-advance state); lfsr[rr_ptr] advances one step; entropy_pool rotates left one bit with feedback bit95^bit47^bit15; key_material updated from the pre-advance state and the pre-rotation pool; rr_ptr increments, wraps NUM_CH-1 → 0.
- Lockup guard: an advance producing all-zero state loads ENTROPY_SOURCE[SEED_WIDTH-1:0] instead.
- Seed load: any cycle with seed_load = 1 suppresses the push (no channel advances, rr_ptr holds); valid seed_ch loaded; rep_cnt cleared; health_fail cleared.
- Pop: random_valid && rd_ready removes the head word. Push and pop in the same cycle: level unchanged; allowed at full only if push condition held (it does not — full blocks push regardless of pop).
- Pop on empty: no effect. fifo_level never exceeds FIFO_DEPTH.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH.

## Timing
- generate_enable sampled at edge N → gen_sync at N; push evaluated at edge N+1; random_valid = 1 after N+1 if FIFO was empty (two-cycle enable-to-valid latency).
- FIFO is first-word-fall-through: head data valid combinationally from storage while random_valid = 1.
- Steady state: one push per cycle while gen_sync = 1 and not full; sustained throughput 1 word/cycle with rd_ready held high.
- seed_load takes effect at the edge it is sampled; next push uses the new seed.
- rst asserted mid-operation: all state returns to reset values at that edge; queued words discarded.

## Configuration
- RNG_HEALTH_TEST_EN defined: rep_cnt counts consecutive pushes whose data equals the previous pushed data (any channel); reaching REP_LIMIT identical words sets health_fail on that push edge; pushes then stop until seed_load or rst; words already queued remain poppable.
- Undefined: rep_cnt/comparator not built; health_fail tied 0; pushes never blocked by health.

## Test plan
- Reset then idle → random_valid 0, fifo_level 0, key_material 0, health_fail 0 for 10 cycles.
- SEED_WIDTH 32, seed_load ch0 with 0x00000001, NUM_CH 1, generate_enable 1, rd_ready 1 → random_out sequence 0x0001, 0x0003, 0x0006, random_ch 0.
- NUM_CH 4, rd_ready 0, generate_enable 1 → exactly 4 pushes, random_ch of heads 0,1,2,3 on pop, fifo_level holds 4, no channel advances further while full.
- seed_load ch2 with 0 → ch2 restarts at ENTROPY_SOURCE[31:0] = 0x12345678; first ch2 output 0x5678; push suppressed in the seed cycle.
- RNG_HEALTH_TEST_EN, all four channels seeded 0x00000001, REP_LIMIT 4 → four pushes of 0x0001, health_fail = 1 on fourth push, no further pushes; seed_load clears it.
- rst pulsed with fifo_level 3 → next cycle fifo_level 0, random_valid 0, rr_ptr back to 0.
